// File: rtl/uart_regs_lite_if.sv
// uart_regs_lite_if: register bus from the Wishbone slave stage (we_i/re_i strobes, adr_i, dat8_i in, dat8_o out)
interface uart_regs_lite_if;
  logic       we_i;
  logic       re_i;
  logic [2:0] adr_i;
  logic [7:0] dat8_i;
  logic [7:0] dat8_o;
  modport master (output we_i, re_i, adr_i, dat8_i, input dat8_o);
  modport slave (input we_i, re_i, adr_i, dat8_i, output dat8_o);
endinterface

// File: rtl/uart_regs_lite.sv
// uart_regs_lite: 16550-style register file with TX/RX byte FIFOs; ports clk, wb_rst_i, bus (uart_regs_lite_if.slave), tx_data_o/tx_valid_o/tx_ready_i/tx_busy_i, rx_data_i/rx_valid_i, int_o; define UART_FIFO_LEVEL_EN to read TX/RX levels at addresses 4/6
module uart_regs_lite #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              wb_rst_i,
  uart_regs_lite_if.slave   bus,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic              tx_busy_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              int_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [AW:0]   tx_lvl, rx_lvl;
  logic [1:0]    ier;
  logic [7:0]    lcr, scr;
  logic          oe;
  logic          wr, rd, tx_push, tx_pop, rx_push, rx_pop, tx_clr, rx_clr;
  logic          rx_full, dr, thre, oe_set, oe_clr;
  logic [7:0]    rbr, iir, lsr;
  // a write strobe masks a simultaneous read strobe entirely
  assign wr      = bus.we_i;
  assign rd      = bus.re_i & ~bus.we_i;
  assign dr      = rx_lvl != '0;
  assign thre    = tx_lvl == '0;
  assign rx_full = rx_lvl == FULL;
  assign tx_valid_o = ~thre;
  assign tx_data_o  = tx_mem[tx_rp];
  assign tx_push = wr & bus.adr_i == 3'd0 & tx_lvl != FULL;
  assign tx_pop  = tx_valid_o & tx_ready_i;
  assign rx_pop  = rd & bus.adr_i == 3'd0 & dr;
  // a full RX FIFO still accepts a byte when the head leaves in the same cycle
  assign rx_push = rx_valid_i & (~rx_full | rx_pop);
  assign oe_set  = rx_valid_i & rx_full & ~rx_pop;
  assign oe_clr  = rd & bus.adr_i == 3'd5;
  assign tx_clr  = wr & bus.adr_i == 3'd2 & bus.dat8_i[2];
  assign rx_clr  = wr & bus.adr_i == 3'd2 & bus.dat8_i[1];
  assign rbr = dr ? rx_mem[rx_rp] : 8'h00;
  assign iir = (ier[0] & dr) ? 8'hC4 : (ier[1] & thre) ? 8'hC2 : 8'hC1;
  assign lsr = {1'b0, thre & ~tx_busy_i, thre, 3'b000, oe, dr};
  always_comb begin
    bus.dat8_o = 8'h00;
    case (bus.adr_i)
      3'd0: bus.dat8_o = rbr;
      3'd1: bus.dat8_o = {6'b0, ier};
      3'd2: bus.dat8_o = iir;
      3'd3: bus.dat8_o = lcr;
`ifdef UART_FIFO_LEVEL_EN
      3'd4: bus.dat8_o = 8'(tx_lvl);
      3'd6: bus.dat8_o = 8'(rx_lvl);
`endif
      3'd5: bus.dat8_o = lsr;
      3'd7: bus.dat8_o = scr;
      default: bus.dat8_o = 8'h00;
    endcase
  end
  // storage needs no reset: pointers and levels define what is valid
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.dat8_i;
    if (rx_push) rx_mem[rx_wp] <= rx_data_i;
  end
  always_ff @(posedge clk) begin
    if (wb_rst_i || tx_clr) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
    end else begin
      tx_wp  <= tx_wp + AW'(tx_push);
      tx_rp  <= tx_rp + AW'(tx_pop);
      tx_lvl <= tx_lvl + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
    if (wb_rst_i || rx_clr) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_lvl <= '0;
      oe     <= 1'b0;
    end else begin
      rx_wp  <= rx_wp + AW'(rx_push);
      rx_rp  <= rx_rp + AW'(rx_pop);
      rx_lvl <= rx_lvl + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
      oe     <= oe_set | (oe & ~oe_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      ier   <= 2'b00;
      lcr   <= 8'h03;
      scr   <= 8'h00;
      int_o <= 1'b0;
    end else begin
      ier   <= (wr && bus.adr_i == 3'd1) ? bus.dat8_i[1:0] : ier;
      lcr   <= (wr && bus.adr_i == 3'd3) ? bus.dat8_i : lcr;
      scr   <= (wr && bus.adr_i == 3'd7) ? bus.dat8_i : scr;
      int_o <= (ier[0] & dr) | (ier[1] & thre);
    end
  end
endmodule

// File: tb/tb_uart_regs_lite.sv
// tb_uart_regs_lite: table-driven register checks plus FIFO corner-case sequences for uart_regs_lite
module tb_uart_regs_lite;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, tx_busy, rx_valid, irq;
  int         tests = 0;
  int         fails = 0;
  int         cnt;
  always #5 clk = ~clk;
  uart_regs_lite_if bus ();
  uart_regs_lite #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .wb_rst_i(rst), .bus(bus),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_busy_i(tx_busy),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .int_o(irq)
  );
  typedef struct {
    logic       we;
    logic       re;
    logic [2:0] adr;
    logic [7:0] din;
    logic       busy;
    logic [7:0] exp_d;
    logic       exp_i;
  } vec_t;
  vec_t vt [23];
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    bus.we_i = 1'b0;
    bus.re_i = 1'b0;
    rx_valid = 1'b0;
  endtask
  task automatic acc(input logic w, input logic r, input logic [2:0] a, input logic [7:0] d);
    bus.we_i = w;
    bus.re_i = r;
    bus.adr_i = a;
    bus.dat8_i = d;
  endtask
  task automatic peek(input string nm, input logic [2:0] a, input logic [7:0] exp);
    bus.adr_i = a;
    #1;
    chk(nm, bus.dat8_o, exp);
  endtask
  task automatic rx_in(input logic [7:0] d);
    rx_data = d;
    rx_valid = 1'b1;
  endtask
  initial begin
    vt = '{
      '{0,1,3'd3,8'h00,0,8'h03,0}, '{0,1,3'd5,8'h00,0,8'h60,0}, '{0,1,3'd2,8'h00,0,8'hC1,0},
      '{0,1,3'd1,8'h00,0,8'h00,0}, '{1,0,3'd3,8'h1B,0,8'h03,0}, '{0,1,3'd3,8'h00,0,8'h1B,0},
      '{1,0,3'd7,8'h5A,0,8'h00,0}, '{0,1,3'd7,8'h00,0,8'h5A,0}, '{1,0,3'd1,8'hFF,0,8'h00,0},
      '{0,1,3'd1,8'h00,0,8'h03,0}, '{0,1,3'd2,8'h00,0,8'hC2,1}, '{1,0,3'd5,8'hFF,0,8'h60,1},
      '{0,1,3'd5,8'h00,0,8'h60,1}, '{1,0,3'd4,8'h77,0,8'h00,1}, '{0,1,3'd4,8'h00,0,8'h00,1},
      '{0,1,3'd6,8'h00,0,8'h00,1}, '{1,0,3'd1,8'h00,0,8'h03,1}, '{0,1,3'd1,8'h00,0,8'h00,1},
      '{0,1,3'd2,8'h00,0,8'hC1,0}, '{0,1,3'd5,8'h00,1,8'h20,0}, '{1,1,3'd7,8'h33,0,8'h5A,0},
      '{0,1,3'd7,8'h00,0,8'h33,0}, '{0,1,3'd0,8'h00,0,8'h00,0}
    };
    tx_ready = 1'b0;
    tx_busy = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    rst = 1'b1;
    acc(1, 0, 3'd3, 8'hFF);
    tick;
    acc(1, 0, 3'd3, 8'hFF);
    tick;
    rst = 1'b0;
    chk("reset_int", {7'b0, irq}, 8'h00);
    chk("reset_txv", {7'b0, tx_valid}, 8'h00);
    for (int i = 0; i < 23; i++) begin
      acc(vt[i].we, vt[i].re, vt[i].adr, vt[i].din);
      tx_busy = vt[i].busy;
      #1;
      chk($sformatf("vec%0d_dat", i), bus.dat8_o, vt[i].exp_d);
      chk($sformatf("vec%0d_int", i), {7'b0, irq}, {7'b0, vt[i].exp_i});
      tick;
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 17; i++) begin
      acc(1, 0, 3'd0, 8'(i));
      tick;
    end
    peek("lsr_tx_full", 3'd5, 8'h00);
    chk("txv_full", {7'b0, tx_valid}, 8'h01);
    tx_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid) begin
        chk($sformatf("tx_byte%0d", cnt), tx_data, 8'(cnt));
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b0;
    chk("tx_count", 8'(cnt), 8'd16);
    peek("lsr_tx_drained", 3'd5, 8'h60);
    acc(1, 0, 3'd0, 8'hA1);
    tick;
    acc(1, 0, 3'd0, 8'hB2);
    tx_ready = 1'b1;
    #1;
    chk("tx_pp_head", tx_data, 8'hA1);
    tick;
    tx_ready = 1'b0;
    chk("tx_pp_valid", {7'b0, tx_valid}, 8'h01);
    chk("tx_pp_data", tx_data, 8'hB2);
    tx_ready = 1'b1;
    tick;
    tx_ready = 1'b0;
    chk("tx_pp_empty", {7'b0, tx_valid}, 8'h00);
    acc(1, 0, 3'd0, 8'hC3);
    tick;
    acc(1, 0, 3'd0, 8'hD4);
    tick;
    acc(1, 0, 3'd2, 8'h04);
    tx_ready = 1'b1;
    tick;
    tx_ready = 1'b0;
    chk("fcr_tx_clr", {7'b0, tx_valid}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      rx_in(8'h80 + 8'(i));
      tick;
    end
    rx_in(8'hAA);
    tick;
    acc(0, 1, 3'd5, 8'h00);
    #1;
    chk("lsr_oe", bus.dat8_o, 8'h63);
    tick;
    peek("lsr_oe_clr", 3'd5, 8'h61);
    for (int i = 0; i < 16; i++) begin
      acc(0, 1, 3'd0, 8'h00);
      #1;
      chk($sformatf("rbr%0d", i), bus.dat8_o, 8'h80 + 8'(i));
      tick;
    end
    peek("lsr_rx_empty", 3'd5, 8'h60);
    for (int i = 0; i < 16; i++) begin
      rx_in(8'h40 + 8'(i));
      tick;
    end
    acc(0, 1, 3'd0, 8'h00);
    rx_in(8'h55);
    #1;
    chk("rbr_full_pop", bus.dat8_o, 8'h40);
    tick;
    peek("lsr_no_oe", 3'd5, 8'h61);
    acc(0, 1, 3'd5, 8'h00);
    rx_in(8'hBB);
    #1;
    chk("lsr_oe_race", bus.dat8_o, 8'h61);
    tick;
    peek("lsr_oe_kept", 3'd5, 8'h63);
    for (int i = 0; i < 16; i++) begin
      acc(0, 1, 3'd0, 8'h00);
      #1;
      chk($sformatf("rbr_wrap%0d", i), bus.dat8_o, i < 15 ? 8'h41 + 8'(i) : 8'h55);
      tick;
    end
    peek("lsr_oe_only", 3'd5, 8'h62);
    acc(1, 0, 3'd2, 8'h02);
    tick;
    peek("fcr_oe_clr", 3'd5, 8'h60);
    acc(1, 0, 3'd1, 8'h01);
    tick;
    rx_in(8'h99);
    tick;
    chk("int_lat0", {7'b0, irq}, 8'h00);
    peek("iir_rx", 3'd2, 8'hC4);
    tick;
    chk("int_high", {7'b0, irq}, 8'h01);
    acc(1, 0, 3'd2, 8'h02);
    tick;
    chk("int_lat1", {7'b0, irq}, 8'h01);
    peek("lsr_fcr_rx", 3'd5, 8'h60);
    tick;
    chk("int_low", {7'b0, irq}, 8'h00);
    acc(1, 0, 3'd0, 8'h11);
    rx_in(8'h22);
    tick;
    acc(1, 0, 3'd7, 8'hEE);
    tick;
    rst = 1'b1;
    acc(1, 0, 3'd0, 8'h33);
    rx_in(8'h44);
    tick;
    rst = 1'b0;
    chk("rst_txv", {7'b0, tx_valid}, 8'h00);
    chk("rst_int", {7'b0, irq}, 8'h00);
    peek("rst_lsr", 3'd5, 8'h60);
    peek("rst_lcr", 3'd3, 8'h03);
    peek("rst_scr", 3'd7, 8'h00);
    peek("rst_ier", 3'd1, 8'h00);
    peek("rst_rbr", 3'd0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
